// File: rtl/rx_control_module.sv
// UART receive sequencer: times start/data/stop sample points from a start-edge
// pulse, assembles data LSB first, and reports a good byte or a framing error.
module rx_control_module #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Rx_En_Sig,
    input  logic                 H2L_Sig,
    input  logic                 RX_Pin_In,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Done_Sig,
    output logic                 Frame_Err_Sig,
    output logic                 Rx_Busy_Sig
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (H2L_Sig && Rx_En_Sig) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                // A line already back high at mid-start is a glitch, not a frame.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!RX_Pin_In) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {RX_Pin_In, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    if (RX_Pin_In) begin
                        state_d = DONE;
                        data_d  = shift_q;
                        done_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign Rx_Data       = data_q;
    assign Rx_Done_Sig   = done_q;
    assign Frame_Err_Sig = err_q;
    assign Rx_Busy_Sig   = busy_q;

endmodule

// File: tb/tb_rx_control_module.sv
// Directed bench for rx_control_module at 16 clocks per bit, 8 data bits.
module tb_rx_control_module;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b1;
    logic       h2l = 1'b0;
    logic       rx_pin = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    logic       prev_line = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    rx_control_module #(
        .CLKS_PER_BIT(16),
        .DATA_BITS   (8)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .Rx_En_Sig    (rx_en),
        .H2L_Sig      (h2l),
        .RX_Pin_In    (rx_pin),
        .Rx_Data      (rx_data),
        .Rx_Done_Sig  (rx_done),
        .Frame_Err_Sig(frame_err),
        .Rx_Busy_Sig  (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Drives one frame (or a glitch) cycle by cycle, with H2L derived from the
    // line like a real falling-edge detector, and records what the DUT did.
    task automatic run_frame(
        input  logic [7:0] d,
        input  logic       stop_b,
        input  int         drop_at,
        input  int         rst_at,
        input  int         glitch_len,
        input  int         ncyc,
        output int         done_at,
        output int         done_cnt,
        output int         err_at,
        output int         err_cnt,
        output int         busy_first,
        output int         busy_last,
        output int         busy_cnt,
        output int         done_abs,
        output int         post_rst
    );
        done_at = -1; done_cnt = 0; err_at = -1; err_cnt = 0;
        busy_first = -1; busy_last = -1; busy_cnt = 0; done_abs = -1; post_rst = -1;
        for (int k = 0; k < ncyc; k++) begin
            logic line;
            int   b;
            b = k / 16;
            if (glitch_len > 0)  line = (k < glitch_len) ? 1'b0 : 1'b1;
            else if (b == 0)     line = 1'b0;
            else if (b <= 8)     line = d[b-1];
            else                 line = stop_b;
            rx_pin    = line;
            h2l       = prev_line & ~line;
            prev_line = line;
            if (k == drop_at) rx_en = 1'b0;
            rst = (k == rst_at);
            if (rx_done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; done_abs = cyc; end
            end
            if (frame_err) begin
                err_cnt++;
                if (err_at < 0) err_at = k;
            end
            if (rx_busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (k == rst_at + 1)
                post_rst = int'({rx_data, rx_done, frame_err, rx_busy});
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        h2l = 1'b0;
    endtask

    initial begin
        int da, dc, ea, ec, bf, bl, bc, dabs, pr, dabs1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("reset_data", int'(rx_data), 0);
        check_val("reset_done", int'(rx_done), 0);
        check_val("reset_err", int'(frame_err), 0);
        check_val("reset_busy", int'(rx_busy), 0);
        repeat (4) begin @(posedge clk); #1; end

        // Good frame 0xA5
        run_frame(8'hA5, 1'b1, -1000, -1000, 0, 165, da, dc, ea, ec, bf, bl, bc, dabs, pr);
        $display("frame A5: done_at=%0d data=%h busy %0d..%0d", da, rx_data, bf, bl);
        check_val("a5_done_at", da, 153);
        check_val("a5_done_cnt", dc, 1);
        check_val("a5_err_cnt", ec, 0);
        check_val("a5_busy_first", bf, 1);
        check_val("a5_busy_last", bl, 152);
        check_val("a5_data", int'(rx_data), 'hA5);

        // Glitch: line low for 3 cycles
        run_frame(8'h00, 1'b1, -1000, -1000, 3, 30, da, dc, ea, ec, bf, bl, bc, dabs, pr);
        $display("glitch: busy_cnt=%0d done=%0d err=%0d", bc, dc, ec);
        check_val("glitch_busy_cnt", bc, 8);
        check_val("glitch_busy_last", bl, 8);
        check_val("glitch_done_cnt", dc, 0);
        check_val("glitch_err_cnt", ec, 0);
        check_val("glitch_data", int'(rx_data), 'hA5);

        // Framing error on 0x3C
        run_frame(8'h3C, 1'b0, -1000, -1000, 0, 160, da, dc, ea, ec, bf, bl, bc, dabs, pr);
        prev_line = 1'b1;
        rx_pin    = 1'b1;
        repeat (4) begin @(posedge clk); #1; cyc++; end
        $display("frame 3C stop0: err_at=%0d err_cnt=%0d data=%h", ea, ec, rx_data);
        check_val("ferr_at", ea, 153);
        check_val("ferr_cnt", ec, 1);
        check_val("ferr_done_cnt", dc, 0);
        check_val("ferr_data", int'(rx_data), 'hA5);

        // Back-to-back 0x00 then 0xFF
        run_frame(8'h00, 1'b1, -1000, -1000, 0, 160, da, dc, ea, ec, bf, bl, bc, dabs1, pr);
        $display("frame 00: done_at=%0d data=%h", da, rx_data);
        check_val("b2b0_done_at", da, 153);
        check_val("b2b0_data", int'(rx_data), 'h00);
        run_frame(8'hFF, 1'b1, -1000, -1000, 0, 165, da, dc, ea, ec, bf, bl, bc, dabs, pr);
        $display("frame FF: done_at=%0d data=%h spacing=%0d", da, rx_data, dabs - dabs1);
        check_val("b2b1_done_at", da, 153);
        check_val("b2b_spacing", dabs - dabs1, 160);
        check_val("b2b1_data", int'(rx_data), 'hFF);

        // Enable low: 0x55 must be ignored entirely
        rx_en = 1'b0;
        run_frame(8'h55, 1'b1, -1000, -1000, 0, 165, da, dc, ea, ec, bf, bl, bc, dabs, pr);
        $display("frame 55 en=0: busy_cnt=%0d done=%0d", bc, dc);
        check_val("en0_busy_cnt", bc, 0);
        check_val("en0_done_cnt", dc, 0);
        check_val("en0_data", int'(rx_data), 'hFF);

        // Enable high, dropped mid-frame: frame still completes
        rx_en = 1'b1;
        run_frame(8'h55, 1'b1, 40, -1000, 0, 165, da, dc, ea, ec, bf, bl, bc, dabs, pr);
        $display("frame 55 drop@40: done_at=%0d data=%h", da, rx_data);
        check_val("endrop_done_at", da, 153);
        check_val("endrop_data", int'(rx_data), 'h55);
        rx_en = 1'b1;

        // Reset mid-frame on 0x81, then a clean 0x42
        run_frame(8'h81, 1'b1, -1000, 60, 0, 165, da, dc, ea, ec, bf, bl, bc, dabs, pr);
        $display("frame 81 rst@60: post_rst=%0d done=%0d err=%0d", pr, dc, ec);
        check_val("rst_outputs", pr, 0);
        check_val("rst_done_cnt", dc, 0);
        check_val("rst_err_cnt", ec, 0);
        run_frame(8'h42, 1'b1, -1000, -1000, 0, 165, da, dc, ea, ec, bf, bl, bc, dabs, pr);
        $display("frame 42: done_at=%0d data=%h", da, rx_data);
        check_val("post_rst_done_at", da, 153);
        check_val("post_rst_data", int'(rx_data), 'h42);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_control_module.md
Name: rx_control_module

Overview:
- UART receive sequencer for the serial RX path.
- Consumes the one-cycle start-edge pulse from the RX falling-edge detector and the synchronised RX line.
- Times the start, data and stop bit sample points, then assembles the data bits LSB first.
- Delivers a completed byte with a one-cycle done strobe, or flags a framing error.

Parameters:
- CLKS_PER_BIT, 434, CLK cycles per serial bit (50 MHz / 115200); legal range >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- Rx_En_Sig  input  1  receive enable; gates frame start only.
- H2L_Sig  input  1  one-cycle pulse marking a high-to-low transition on the RX line.
- RX_Pin_In  input  1  RX line, already synchronised to CLK.
- Rx_Data  output  DATA_BITS  last good received byte, LSB = first data bit.
- Rx_Done_Sig  output  1  one-cycle strobe: Rx_Data updated with a good frame.
- Frame_Err_Sig  output  1  one-cycle strobe: stop bit sampled low.
- Rx_Busy_Sig  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST high at a CLK edge):
  - State goes to IDLE; counters and the shift register clear.
  - Rx_Data = 0, Rx_Done_Sig = 0, Frame_Err_Sig = 0, Rx_Busy_Sig = 0.
  - Reset takes priority over every other event, including mid-frame; a partial frame is discarded.
- States: IDLE, START, DATA, STOP, DONE.
- Bit counter: width $clog2(CLKS_PER_BIT). Bit index counter: counts 0..DATA_BITS-1.
- IDLE:
  - If H2L_Sig = 1 and Rx_En_Sig = 1, go to START, clear the bit counter and set Rx_Busy_Sig = 1 from the next cycle.
  - H2L_Sig is ignored when Rx_En_Sig = 0.
- START:
  - Count CLKS_PER_BIT/2 cycles (integer division) after the pulse cycle t0; this is the mid-start sample at t0 + CLKS_PER_BIT/2.
  - RX_Pin_In = 0 at the sample: go to DATA, restart the counter.
  - RX_Pin_In = 1 at the sample: treat as a glitch, go to IDLE and drop Rx_Busy_Sig next cycle. No strobe fires.
- DATA:
  - Sample bit i at t0 + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT.
  - Shift the sample into the shift register, LSB first.
  - After bit DATA_BITS-1, go to STOP.
- STOP:
  - Sample at t0 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT.
  - Sample = 1: go to DONE.
  - Sample = 0: pulse Frame_Err_Sig for one cycle (the cycle after the sample), leave Rx_Data unchanged, go to IDLE.
- DONE:
  - Rx_Data loads the shift register and Rx_Done_Sig = 1 for exactly that cycle.
  - Rx_Busy_Sig = 0 from the same cycle; next state is IDLE.
- Latency: Rx_Done_Sig is high exactly one cycle after the stop sample cycle.
- Back-to-back frames: the controller is back in IDLE before the stop bit ends, so a start edge arriving in the next bit period is accepted.
- H2L_Sig pulses outside IDLE are ignored.
- Rx_En_Sig deasserted mid-frame: the current frame completes normally, and no new frame starts.
- Rx_Data holds its value between good frames.
- Rx_Done_Sig and Frame_Err_Sig are mutually exclusive and never high for two consecutive cycles from the same frame.
- Counters never wrap inside a bit: each counter reloads to 0 at every sample point.

Test Plan:
- CLKS_PER_BIT = 16, DATA_BITS = 8, send 0xA5 (8N1) after reset.
  - Response: Rx_Done_Sig high exactly at t0 + 8 + 9*16 + 1 = t0 + 153 for one cycle; Rx_Data = 0xA5.
  - Rx_Busy_Sig is high from t0+1 through t0+152.
- Glitch: RX low for 3 cycles (H2L_Sig pulses once).
  - Response: Rx_Busy_Sig high for 8 cycles, then low.
  - No Rx_Done_Sig or Frame_Err_Sig; Rx_Data unchanged.
- Frame error: send 0x3C with the stop bit driven 0.
  - Response: Frame_Err_Sig pulses once at t0 + 153; Rx_Data keeps its previous value (0xA5).
- Back-to-back: send 0x00, then 0xFF, with zero idle between frames.
  - Response: two Rx_Done_Sig pulses 160 cycles apart; Rx_Data = 0x00, then 0xFF.
- Enable gating:
  - Rx_En_Sig = 0, send 0x55: no activity at all.
  - Raise Rx_En_Sig, send 0x55, then drop Rx_En_Sig at t0 + 40: frame completes with Rx_Done_Sig and Rx_Data = 0x55.
- Reset mid-frame: assert RST for 1 cycle at t0 + 60 during 0x81.
  - Response: all outputs 0 on the next cycle, no strobe from that frame.
  - A following frame 0x42 receives correctly.
